// File: rtl/uart_rx_ctrl_if.sv
// Receive-byte handshake between uart_rx_ctrl and its consumer.
interface uart_rx_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive sequencer: start-bit qualification, baud-generator
// enable ownership, data/stop sampling on bit strobes and byte handshake.
module uart_rx_ctrl #(
  parameter int unsigned HALF_THR = 521
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rxd,
  input  logic           rx_br_stb,
  output logic           rx_br_en,
  output logic           frame_err,
  output logic           overrun,
  uart_rx_ctrl_if.master rx
);

  localparam logic [10:0] LP_HALF = 11'(HALF_THR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1;
  logic        r_rxd_s;
  logic        r_rxd_d;
  logic        w_fall;
  logic [10:0] r_half_cnt;
  logic [10:0] w_half_inc;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_br_en;
  logic        r_frame_err;
  logic        r_overrun;
  logic        w_shift_en;
  logic        w_stop_smp;
  logic        w_good;
  logic        w_load;

  assign w_fall     = r_rxd_d & ~r_rxd_s;
  // Comparing the incremented count makes the DATA decision land HALF_THR
  // cycles after the edge-detect cycle, so rx_br_en rises HALF_THR+1 later.
  assign w_half_inc = r_half_cnt + 11'd1;
  assign w_good     = w_stop_smp & r_rxd_s;
  assign w_load     = w_good & (~r_valid | rx.rx_ready);

  assign rx_br_en    = r_br_en;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign rx.rx_data  = r_data;
  assign rx.rx_valid = r_valid;

  // Two-flop synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_rxd_s <= r_sync1;
      r_rxd_d <= r_rxd_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_START;
      end
      ST_START: begin
        if (r_rxd_s) w_state_nxt = ST_IDLE;
        else if (w_half_inc == LP_HALF) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (rx_br_stb) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (rx_br_stb) begin
          w_stop_smp  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Half-bit counter, bit counter, shift register and baud enable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_br_en    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE) r_half_cnt <= '0;
      else if (r_state == ST_START) r_half_cnt <= w_half_inc;
      if (r_state == ST_START && w_state_nxt == ST_DATA) r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= {r_rxd_s, r_shift[7:1]};
      r_br_en <= (w_state_nxt == ST_DATA) || (w_state_nxt == ST_STOP);
    end
  end

  // Byte presentation, handshake and status pulses from the stop sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_smp & ~r_rxd_s;
      r_overrun   <= w_good & r_valid & ~rx.rx_ready;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a behavioural baud generator, run at a
// scaled bit period to keep frames short.
module tb_uart_rx_ctrl;

  localparam int unsigned BIT  = 104;
  localparam int unsigned HALF = 52;
  localparam int K_BYTE = 0;
  localparam int K_FE   = 1;
  localparam int K_OVR  = 2;

  logic clk = 1'b0;
  logic rstn;
  logic rxd;
  logic rx_br_stb;
  logic rx_br_en;
  logic frame_err;
  logic overrun;

  uart_rx_ctrl_if rx_if ();

  uart_rx_ctrl #(.HALF_THR(HALF)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .rxd       (rxd),
    .rx_br_stb (rx_br_stb),
    .rx_br_en  (rx_br_en),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx        (rx_if)
  );

  always #5 clk = ~clk;

  // Baud generator stand-in: counter held at 0 while disabled, one strobe per bit.
  int unsigned gen_cnt;
  int unsigned stb_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_cnt <= 0;
      stb_cnt <= 0;
    end else if (!rx_br_en) begin
      gen_cnt <= 0;
      stb_cnt <= 0;
    end else if (gen_cnt == BIT - 1) begin
      gen_cnt <= 0;
      stb_cnt <= stb_cnt + 1;
    end else begin
      gen_cnt <= gen_cnt + 1;
    end
  end
  assign rx_br_stb = rx_br_en && (gen_cnt == BIT - 1);

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    logic       ready;
    int         kind;
    logic [7:0] exp_byte;
    logic       post_valid;
    logic [7:0] post_data;
  } vec_t;
  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_event(input int kind, input logic [7:0] data);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got event kind %0d data %0h expected none", kind, data);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", kind, e.kind);
      if (e.kind == K_BYTE) check("sb_data", data, e.data);
    end
  endtask

  // Handshake seen at each edge, sampled before the edge updates outputs.
  logic v_q  = 1'b0;
  logic hs_q = 1'b0;
  always @(posedge clk) begin
    v_q  <= rx_if.rx_valid;
    hs_q <= rx_if.rx_valid & rx_if.rx_ready;
  end

  // Output monitor: a byte load is valid high after either no byte or a taken byte.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (frame_err) sb_event(K_FE, 8'h00);
      if (overrun) sb_event(K_OVR, 8'h00);
      if (rx_if.rx_valid && (!v_q || hs_q)) sb_event(K_BYTE, rx_if.rx_data);
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stopv);
    logic [9:0] bits;
    bits = {stopv, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = bits[i];
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int unsigned n);
    @(negedge clk);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_en_rise();
    int unsigned n;
    @(negedge clk);
    n = 0;
    while (!rx_br_en && n < 3 * BIT) begin
      @(negedge clk);
      n++;
    end
    check("en_rise_delay", n, HALF + 3);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int unsigned n;
    bit en_seen;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, K_BYTE, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, K_FE,   8'h00, 1'b0, 8'hA5};
    vecs[2] = '{8'h11, 1'b1, 1'b0, K_BYTE, 8'h11, 1'b1, 8'h11};
    vecs[3] = '{8'h22, 1'b1, 1'b0, K_OVR,  8'h00, 1'b1, 8'h11};

    rstn = 1'b0;
    rxd = 1'b1;
    rx_if.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_br_en", rx_br_en, 0);
    check("rst_data", rx_if.rx_data, 0);
    check("rst_valid", rx_if.rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rstn = 1'b1;
    idle(BIT);

    for (int i = 0; i < 4; i++) begin
      rx_if.rx_ready = vecs[i].ready;
      e.kind = vecs[i].kind;
      e.data = vecs[i].exp_byte;
      sb_q.push_back(e);
      fork
        send_frame(vecs[i].data, vecs[i].stopv);
        measure_en_rise();
      join
      idle(2 * BIT);
      check("vec_sb_drained", sb_q.size(), 0);
      check("vec_post_valid", rx_if.rx_valid, vecs[i].post_valid);
      check("vec_post_data", rx_if.rx_data, vecs[i].post_data);
      check("vec_br_en_low", rx_br_en, 0);
    end

    // Glitch shorter than half a bit must not start a frame.
    en_seen = 1'b0;
    @(negedge clk);
    rxd = 1'b0;
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 3 * BIT; i++) begin
      @(negedge clk);
      if (rx_br_en) en_seen = 1'b1;
    end
    check("glitch_no_en", en_seen, 0);
    check("glitch_data", rx_if.rx_data, 8'h11);
    check("glitch_valid", rx_if.rx_valid, 1);

    // Consumer takes 0x11 in the very cycle 0x55 completes.
    rx_if.rx_ready = 1'b0;
    e.kind = K_BYTE;
    e.data = 8'h55;
    sb_q.push_back(e);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge clk);
        n = 0;
        while (!(rx_br_stb && stb_cnt == 8) && n < 12 * BIT) begin
          @(negedge clk);
          n++;
        end
        check("stop_strobe_found", n < 12 * BIT, 1);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        check("same_cycle_valid", rx_if.rx_valid, 1);
        check("same_cycle_data", rx_if.rx_data, 8'h55);
      end
    join
    idle(2 * BIT);
    check("same_cycle_sb_drained", sb_q.size(), 0);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", rx_if.rx_valid, 0);
    check("drain_data_kept", rx_if.rx_data, 8'h55);

    // Reset in the middle of data bit 4, then a clean 0xFF frame.
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
    repeat (5 * BIT + BIT / 2) @(negedge clk);
    check("midframe_en_high", rx_br_en, 1);
    rstn = 1'b0;
    #1;
    check("midreset_br_en", rx_br_en, 0);
    check("midreset_data", rx_if.rx_data, 0);
    check("midreset_valid", rx_if.rx_valid, 0);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    idle(2 * BIT);
    e.kind = K_BYTE;
    e.data = 8'hFF;
    sb_q.push_back(e);
    fork
      send_frame(8'hFF, 1'b1);
      measure_en_rise();
    join
    idle(2 * BIT);
    check("post_reset_sb_drained", sb_q.size(), 0);
    check("post_reset_data", rx_if.rx_data, 8'hFF);
    check("post_reset_valid", rx_if.rx_valid, 0);
    check("post_reset_br_en", rx_br_en, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive sequencer for the 9600 bps, 8N1 link at 10 MHz. Detects and qualifies the start bit, owns `rx_br_en` to the `baudrate_gen` RX counter, samples eight data bits and the stop bit on `rx_br_stb`, and presents each byte on a valid/ready handshake. Sits between the synchronised `rxd` pad and the RX consumer (FIFO or register file).

## Interface
- `HALF_THR`, default 521: cycles from the detected falling edge to the start-bit mid-point check (half of the 1042-cycle bit period).
- `clk` input 1: system clock, 10 MHz.
- `rstn` input 1: asynchronous, active-low reset.
- `rxd` input 1: raw serial line, asynchronous, idle high.
- `rx_br_stb` input 1: one-cycle bit strobe from `baudrate_gen`.
- `rx_br_en` output 1: registered enable to `baudrate_gen`. While low, the generator's RX counter is held at 0.
- `rx_data` output 8: last received byte, LSB first on the line.
- `rx_valid` output 1: `rx_data` holds an unconsumed byte.
- `rx_ready` input 1: consumer accepts the byte when high with `rx_valid`.
- `frame_err` output 1: one-cycle pulse when the stop bit samples 0.
- `overrun` output 1: one-cycle pulse when a good frame completes while the previous byte is still unconsumed.

## Operation
- **Input sync:** `rxd` passes through a 2-FF synchroniser (reset value 1) giving `rxd_s`. A third FF `rxd_d` holds the previous `rxd_s`. Falling edge is `rxd_d & ~rxd_s`.
- **FSM states:** IDLE, START, DATA, STOP. Reset state is IDLE.
- **IDLE:**
  - `rx_br_en` is 0.
  - On a falling edge: clear the half counter, go to START.
- **START:**
  - Half counter (11 bits) increments each cycle.
  - If `rxd_s` is 1 before the count reaches `HALF_THR`: glitch, return to IDLE.
  - At count == `HALF_THR` with `rxd_s` 0: go to DATA, set `rx_br_en`=1, clear bit counter.
- **DATA:**
  - `rx_br_en` is 1.
  - On each `rx_br_stb`: shift register loads `{rxd_s, sh[7:1]}`, bit counter (3 bits) increments.
  - On the strobe with bit counter == 7: go to STOP.
  - Cycles without a strobe hold all state.
- **STOP:**
  - `rx_br_en` is 1.
  - On `rx_br_stb`, sample `rxd_s`, then go to IDLE with `rx_br_en`=0 on the next cycle.
  - If the sample is 1 and either `rx_valid`=0 or `rx_ready`=1: load `rx_data` from the shift register and set `rx_valid`=1.
  - If the sample is 1, `rx_valid`=1 and `rx_ready`=0: pulse `overrun`; `rx_data` and `rx_valid` are unchanged and the new byte is dropped.
  - If the sample is 0: pulse `frame_err`; `rx_data`/`rx_valid` are untouched and no overrun is flagged.
- **Handshake:**
  - `rx_valid` and `rx_ready` both high in a cycle clears `rx_valid` next cycle, unless a good frame completes in the same cycle. In that case the new byte loads and `rx_valid` stays 1.
  - `rx_data` is stable while `rx_valid`=1.
- **Line activity:** a falling edge on `rxd` outside IDLE is ignored. No re-arm occurs mid-frame.
- **Reset mid-frame:** everything returns to reset values immediately, and the FSM waits for a fresh falling edge.

## Timing
- **Reset values:**
  - `rx_br_en`=0, `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0.
  - State = IDLE; counters and shift register = 0; sync FFs = 1.
- **Input latency:** edge detect fires 2 cycles after `rxd` falls, assuming `rxd` is sampled stable.
- **Start qualification:** `rx_br_en` rises `HALF_THR`+1 cycles after the edge-detect cycle.
- **Bit sampling:**
  - `baudrate_gen` asserts its first strobe 1043 cycles after `rx_br_en` rises.
  - Each sample therefore lands about 1 bit period after the previous mid-point.
  - Nine strobes are consumed per frame (8 data + stop).
- **Outputs:** `rx_valid`, `frame_err` and `overrun` are registered and change the cycle after the stop-bit strobe.
- **Frame length:** about 9.5 bit periods from the start edge to `rx_valid`, i.e. about 9900 cycles.
- **Back-to-back frames:** the next start edge is accepted from the first IDLE cycle, so frames with zero idle gap are received.

## Test plan
All scenarios drive `rxd` at 1042 cycles/bit into a `baudrate_gen` + `uart_rx_ctrl` pair.
- **Basic byte:** reset with `rxd`=1 -> all outputs 0. Send 0xA5 with good stop, `rx_ready`=1 -> `rx_valid` pulses 1 cycle, `rx_data`=0xA5, `rx_br_en` falls after the stop strobe.
- **Glitch rejection:** `rxd` low for 300 cycles, then high -> FSM returns to IDLE, `rx_br_en` never rises, no outputs change.
- **Framing error:** send 0x3C with stop bit 0 -> `frame_err` pulses 1 cycle, `rx_valid` stays 0, `rx_data` keeps its previous value.
- **Overrun:** hold `rx_ready`=0, send 0x11 then 0x22 -> `rx_valid`=1 with `rx_data`=0x11. At end of the second frame `overrun` pulses and `rx_data` stays 0x11.
- **Accept and complete in the same cycle:** assert `rx_ready` in the exact cycle a second good frame (0x55) completes -> `rx_valid` stays 1, `rx_data`=0x55, no overrun.
- **Reset mid-frame:** pulse `rstn` low during data bit 4 -> `rx_br_en`=0 and state returns to IDLE at once. A following full frame 0xFF is received correctly.
